// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU datapath sequencer.
// Holds the state/kind encodings, ALU op codes and writeback select values.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        EXEC   = 3'd3,
        WRITE  = 3'd4,
        DONE   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        KIND_ALU  = 2'b00,
        KIND_CMP  = 2'b01,
        KIND_MOVI = 2'b10,
        KIND_MOVR = 2'b11
    } kind_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_NOT = 2'b11;

    localparam logic VSEL_C   = 1'b0;
    localparam logic VSEL_IMM = 1'b1;

    // MOV imm skips operand fetch entirely; MOV reg only needs the B operand.
    function automatic state_t first_state(input kind_t k);
        case (k)
            KIND_MOVI: first_state = WRITE;
            KIND_MOVR: first_state = LOAD_B;
            default:   first_state = LOAD_A;
        endcase
    endfunction

endpackage

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle controller sequencing register-file, shifter and ALU strobes
// for one operation at a time, with a valid/ready request port and done pulse.
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int RADDR_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [1:0]         req_kind,
    input  logic [1:0]         req_aluop,
    input  logic [RADDR_W-1:0] req_rd,
    input  logic [RADDR_W-1:0] req_rn,
    input  logic [RADDR_W-1:0] req_rm,
    input  logic [1:0]         req_shift,
    input  logic [DATA_W-1:0]  req_imm,
    output logic [RADDR_W-1:0] readnum,
    output logic [RADDR_W-1:0] writenum,
    output logic               write,
    output logic               loada,
    output logic               loadb,
    output logic               loadc,
    output logic               loads,
    output logic               asel,
    output logic               bsel,
    output logic               vsel,
    output logic [1:0]         shift,
    output logic [1:0]         aluop,
    output logic [DATA_W-1:0]  imm_out,
    output logic               done,
    output logic               busy
);

    state_t               state;
    state_t               state_nxt;
    kind_t                kind_q;
    logic [RADDR_W-1:0]   rd_q;
    logic [RADDR_W-1:0]   rn_q;
    logic [RADDR_W-1:0]   rm_q;
    logic [1:0]           aluop_q;
    logic [1:0]           shift_q;
    logic [DATA_W-1:0]    imm_q;
    logic                 accept;

    assign req_ready = (state == IDLE);
    assign busy      = ~req_ready;
    assign accept    = req_valid && req_ready;
    assign shift     = shift_q;
    assign imm_out   = imm_q;

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = accept ? first_state(kind_t'(req_kind)) : IDLE;
            LOAD_A:  state_nxt = LOAD_B;
            LOAD_B:  state_nxt = EXEC;
            EXEC:    state_nxt = (kind_q == KIND_CMP) ? DONE : WRITE;
            WRITE:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            kind_q  <= KIND_ALU;
            rd_q    <= '0;
            rn_q    <= '0;
            rm_q    <= '0;
            aluop_q <= '0;
            shift_q <= '0;
            imm_q   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                kind_q  <= kind_t'(req_kind);
                rd_q    <= req_rd;
                rn_q    <= req_rn;
                rm_q    <= req_rm;
                aluop_q <= req_aluop;
                shift_q <= req_shift;
                imm_q   <= req_imm;
            end
        end
    end

    // Strobes decode purely from state, so an async reset drops them at once.
    always_comb begin
        readnum  = '0;
        writenum = '0;
        write    = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        vsel     = VSEL_C;
        done     = 1'b0;
        aluop    = aluop_q;
        case (state)
            LOAD_A: begin
                readnum = rn_q;
                loada   = 1'b1;
            end
            LOAD_B: begin
                readnum = rm_q;
                loadb   = 1'b1;
            end
            EXEC: begin
                loadc = (kind_q != KIND_CMP);
                loads = (kind_q != KIND_MOVI);
                asel  = (kind_q == KIND_MOVR);
                if (kind_q == KIND_MOVR) begin
                    aluop = OP_ADD;
                end
            end
            WRITE: begin
                writenum = rd_q;
                write    = 1'b1;
                vsel     = (kind_q == KIND_MOVI) ? VSEL_IMM : VSEL_C;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                done = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed scoreboard bench for alu_seq_ctrl: each request pushes its per-cycle
// expected strobe pattern, which is popped and checked one cycle at a time.
module tb_alu_seq_ctrl;
    import alu_seq_pkg::*;

    localparam int DATA_W  = 16;
    localparam int RADDR_W = 3;
    localparam logic L = 1'b0;
    localparam logic H = 1'b1;

    logic               clk;
    logic               rst_n;
    logic               req_valid;
    logic               req_ready;
    logic [1:0]         req_kind;
    logic [1:0]         req_aluop;
    logic [RADDR_W-1:0] req_rd;
    logic [RADDR_W-1:0] req_rn;
    logic [RADDR_W-1:0] req_rm;
    logic [1:0]         req_shift;
    logic [DATA_W-1:0]  req_imm;
    logic [RADDR_W-1:0] readnum;
    logic [RADDR_W-1:0] writenum;
    logic               write;
    logic               loada;
    logic               loadb;
    logic               loadc;
    logic               loads;
    logic               asel;
    logic               bsel;
    logic               vsel;
    logic [1:0]         shift;
    logic [1:0]         aluop;
    logic [DATA_W-1:0]  imm_out;
    logic               done;
    logic               busy;

    alu_seq_ctrl #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_kind(req_kind), .req_aluop(req_aluop),
        .req_rd(req_rd), .req_rn(req_rn), .req_rm(req_rm),
        .req_shift(req_shift), .req_imm(req_imm),
        .readnum(readnum), .writenum(writenum), .write(write),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .bsel(bsel), .vsel(vsel),
        .shift(shift), .aluop(aluop), .imm_out(imm_out),
        .done(done), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // strobes = {req_ready, busy, write, loada, loadb, loadc, loads, asel, bsel, vsel, done}
    typedef struct {
        string       tag;
        logic [10:0] strobes;
        logic        rn_care;
        logic [2:0]  readnum;
        logic        wn_care;
        logic [2:0]  writenum;
        logic        op_care;
        logic [1:0]  aluop;
        logic [1:0]  shift;
        logic [15:0] imm;
    } exp_t;

    exp_t sb[$];
    int   n_vectors = 0;
    int   n_miscompares = 0;

    function automatic exp_t mk(input string tag, input logic rdy, input logic wr,
                                input logic la, input logic lb, input logic lc,
                                input logic ls, input logic as, input logic vs,
                                input logic dn, input logic rnc, input logic [2:0] rnum,
                                input logic wnc, input logic [2:0] wnum, input logic opc,
                                input logic [1:0] aop, input logic [1:0] sh,
                                input logic [15:0] im);
        exp_t e;
        e.tag      = tag;
        e.strobes  = {rdy, ~rdy, wr, la, lb, lc, ls, as, 1'b0, vs, dn};
        e.rn_care  = rnc;
        e.readnum  = rnum;
        e.wn_care  = wnc;
        e.writenum = wnum;
        e.op_care  = opc;
        e.aluop    = aop;
        e.shift    = sh;
        e.imm      = im;
        return e;
    endfunction

    function automatic string tagf(input string nm, input int c);
        return $sformatf("%s_c%0d", nm, c);
    endfunction

    // Expected cycle-by-cycle behaviour after the accept edge, ending with the IDLE cycle.
    task automatic pushOp(input string nm, input logic [1:0] k, input logic [1:0] aop,
                          input logic [2:0] rd, input logic [2:0] rn, input logic [2:0] rm,
                          input logic [1:0] sh, input logic [15:0] im);
        int   c;
        logic movr;
        logic movi;
        logic cmp;
        c    = 1;
        movr = (k == 2'b11);
        movi = (k == 2'b10);
        cmp  = (k == 2'b01);
        if (!movi && !movr) begin
            sb.push_back(mk(tagf(nm, c), L, L, H, L, L, L, L, L, L,
                            H, rn, L, 3'd0, H, aop, sh, im));
            c++;
        end
        if (!movi) begin
            sb.push_back(mk(tagf(nm, c), L, L, L, H, L, L, L, L, L,
                            H, rm, L, 3'd0, !movr, aop, sh, im));
            c++;
            sb.push_back(mk(tagf(nm, c), L, L, L, L, !cmp, H, movr, L, L,
                            L, 3'd0, L, 3'd0, H, movr ? 2'b00 : aop, sh, im));
            c++;
        end
        if (!cmp) begin
            sb.push_back(mk(tagf(nm, c), L, H, L, L, L, L, L, movi, L,
                            L, 3'd0, H, rd, !movr, aop, sh, im));
            c++;
        end
        sb.push_back(mk(tagf(nm, c), L, L, L, L, L, L, L, L, H,
                        L, 3'd0, L, 3'd0, !movr, aop, sh, im));
        c++;
        sb.push_back(mk(tagf(nm, c), H, L, L, L, L, L, L, L, L,
                        L, 3'd0, L, 3'd0, !movr, aop, sh, im));
    endtask

    task automatic compareEntry(input exp_t e);
        logic [10:0] obs;
        obs = {req_ready, busy, write, loada, loadb, loadc, loads, asel, bsel, vsel, done};
        n_vectors++;
        assert (obs === e.strobes) else begin
            n_miscompares++;
            $error("[TB] FAIL %s strobes: got %b, want %b", e.tag, obs, e.strobes);
        end
        if (e.rn_care) begin
            n_vectors++;
            assert (readnum === e.readnum) else begin
                n_miscompares++;
                $error("[TB] FAIL %s readnum: got %0d, want %0d", e.tag, readnum, e.readnum);
            end
        end
        if (e.wn_care) begin
            n_vectors++;
            assert (writenum === e.writenum) else begin
                n_miscompares++;
                $error("[TB] FAIL %s writenum: got %0d, want %0d", e.tag, writenum, e.writenum);
            end
        end
        if (e.op_care) begin
            n_vectors++;
            assert (aluop === e.aluop) else begin
                n_miscompares++;
                $error("[TB] FAIL %s aluop: got %b, want %b", e.tag, aluop, e.aluop);
            end
        end
        n_vectors++;
        assert (shift === e.shift && imm_out === e.imm) else begin
            n_miscompares++;
            $error("[TB] FAIL %s shift/imm: got %b/%h, want %b/%h",
                   e.tag, shift, imm_out, e.shift, e.imm);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        @(negedge clk);
        e = sb.pop_front();
        compareEntry(e);
    endtask

    task automatic drainQueue();
        while (sb.size() > 0) checkOutput();
    endtask

    // Drives one request shortly after a falling edge; it is accepted on the next rising edge.
    task automatic applyStimulus(input string nm, input logic [1:0] k, input logic [1:0] aop,
                                 input logic [2:0] rd, input logic [2:0] rn, input logic [2:0] rm,
                                 input logic [1:0] sh, input logic [15:0] im, input logic hold);
        req_kind  = k;
        req_aluop = aop;
        req_rd    = rd;
        req_rn    = rn;
        req_rm    = rm;
        req_shift = sh;
        req_imm   = im;
        req_valid = 1'b1;
        #1;
        n_vectors++;
        assert (req_ready === 1'b1) else begin
            n_miscompares++;
            $error("[TB] FAIL %s_ready: got %b, want 1", nm, req_ready);
        end
        pushOp(nm, k, aop, rd, rn, rm, sh, im);
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t rst_exp;
        rst_exp   = mk("reset", H, L, L, L, L, L, L, L, L,
                       L, 3'd0, L, 3'd0, H, 2'b00, 2'b00, 16'h0000);
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_kind  = 2'b00;
        req_aluop = 2'b00;
        req_rd    = 3'd0;
        req_rn    = 3'd0;
        req_rm    = 3'd0;
        req_shift = 2'b00;
        req_imm   = 16'h0000;
        #12;
        compareEntry(rst_exp);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        compareEntry(rst_exp);

        applyStimulus("alu_add", 2'b00, 2'b00, 3'd3, 3'd1, 3'd2, 2'b00, 16'h0000, L);
        drainQueue();

        applyStimulus("cmp", 2'b01, 2'b01, 3'd6, 3'd4, 3'd4, 2'b00, 16'h0000, L);
        drainQueue();

        applyStimulus("movi", 2'b10, 2'b00, 3'd7, 3'd0, 3'd0, 2'b00, 16'h00AB, L);
        drainQueue();

        applyStimulus("alu_and", 2'b00, 2'b10, 3'd5, 3'd6, 3'd7, 2'b11, 16'h5A5A, L);
        drainQueue();

        // Back-to-back: valid stays high and the second request waits through DONE.
        applyStimulus("b2b_a", 2'b00, 2'b01, 3'd1, 3'd2, 3'd6, 2'b10, 16'h1234, H);
        req_kind  = 2'b10;
        req_aluop = 2'b11;
        req_rd    = 3'd5;
        req_rn    = 3'd3;
        req_rm    = 3'd4;
        req_shift = 2'b01;
        req_imm   = 16'hBEEF;
        drainQueue();
        pushOp("b2b_b", 2'b10, 2'b11, 3'd5, 3'd3, 3'd4, 2'b01, 16'hBEEF);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        drainQueue();

        // Reset during LOAD_B abandons the operation before any write.
        applyStimulus("rst_mid", 2'b00, 2'b00, 3'd2, 3'd3, 3'd4, 2'b01, 16'h0F0F, L);
        checkOutput();
        checkOutput();
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        rst_exp.tag = "rst_mid_async";
        compareEntry(rst_exp);
        @(posedge clk);
        #1;
        rst_exp.tag = "rst_mid_held";
        compareEntry(rst_exp);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus("movr", 2'b11, 2'b10, 3'd0, 3'd1, 3'd5, 2'b01, 16'h00C3, L);
        drainQueue();

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Multi-cycle controller that sequences the register-file + shifter + ALU datapath for one operation at a time.
- Accepts an operation request over a valid/ready handshake and drives the datapath's per-cycle load, select and write strobes.
- Signals completion with a one-cycle done pulse.
- Sits between an instruction source (test harness, later the instruction decoder) and the datapath.

Parameters:
- DATA_W, 16, datapath word width (immediate width).
- RADDR_W, 3, register-file address width (8 registers).

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept; high only in IDLE.
- req_kind  in  2  00=ALU reg-reg, 01=CMP, 10=MOV imm, 11=MOV reg.
- req_aluop  in  2  ALU op code (00 add, 01 sub, 10 and, 11 not-B).
- req_rd  in  RADDR_W  destination register.
- req_rn  in  RADDR_W  A-operand register.
- req_rm  in  RADDR_W  B-operand register.
- req_shift  in  2  shifter control for the B operand.
- req_imm  in  DATA_W  immediate for MOV imm.
- readnum  out  RADDR_W  register-file read address.
- writenum  out  RADDR_W  register-file write address.
- write  out  1  register-file write enable.
- loada  out  1  load the A register.
- loadb  out  1  load the B register.
- loadc  out  1  load the C (result) register.
- loads  out  1  load the status (Z) register.
- asel  out  1  1 = force the A operand to 0.
- bsel  out  1  reserved, held 0.
- vsel  out  1  writeback source: 0 = C, 1 = imm_out.
- shift  out  2  latched shift control.
- aluop  out  2  latched ALU op.
- imm_out  out  DATA_W  latched immediate.
- done  out  1  one-cycle completion pulse.
- busy  out  1  equals ~req_ready.

Behaviour:
- Reset (rst_n low, async):
  - State goes to IDLE.
  - All strobes (write, loada, loadb, loadc, loads, done) = 0.
  - asel, bsel, vsel = 0.
  - Latched fields (rd, rn, rm, aluop, shift, imm, kind) = 0.
  - req_ready = 1, busy = 0.
- Handshake:
  - Accept occurs when req_valid && req_ready on a rising edge; all req_* fields are latched at that edge.
  - req_ready is combinational from state and high only in IDLE, so back-to-back requests are separated by the DONE cycle.
  - req_* are ignored when not accepted.
- States: IDLE, LOAD_A, LOAD_B, EXEC, WRITE, DONE. Outputs are Moore-decoded from state plus latched fields.
  - LOAD_A: readnum = rn; loada = 1.
  - LOAD_B: readnum = rm; loadb = 1.
  - EXEC: loadc = 1 except for CMP; loads = 1 for ALU/CMP/MOV reg; asel = 1 for MOV reg; aluop = latched op, forced 00 for MOV reg.
  - WRITE: writenum = rd; write = 1; vsel = 1 for MOV imm, else 0.
  - DONE: done = 1 → IDLE.
- Transitions after accept, with cycle count from the accept edge to the done-high cycle:
  - ALU: LOAD_A → LOAD_B → EXEC → WRITE → DONE (5).
  - CMP: LOAD_A → LOAD_B → EXEC → DONE (4); no write.
  - MOV imm: WRITE → DONE (2).
  - MOV reg: LOAD_B → EXEC → WRITE → DONE (4); ALU result is 0 + shifted Rm.
- Strobe exclusivity:
  - Each strobe is high for exactly one cycle per operation.
  - write never asserts outside WRITE.
  - At most one of loada/loadb/loadc is high in any cycle.
- shift, aluop and imm_out hold their latched values from accept until the next accept.
- Reset mid-operation: immediate return to IDLE; any pending write is abandoned (write is low from the reset assertion onward).
- Illegal state encodings → IDLE on the next edge.
- No arithmetic in this block; widths pass through unchanged.

Decomposition:
- Shared package alu_seq_pkg:
  - state_t enum: IDLE, LOAD_A, LOAD_B, EXEC, WRITE, DONE.
  - kind_t enum: KIND_ALU, KIND_CMP, KIND_MOVI, KIND_MOVR.
  - ALU op constants: OP_ADD, OP_SUB, OP_AND, OP_NOT.
  - VSEL_C / VSEL_IMM constants.
- Single module; no sub-module. Next-state logic and output decode are separate always blocks inside it.

Test Plan:
- Reset: rst_n = 0 then 1 → req_ready = 1, busy = 0, all strobes 0, state IDLE.
- ALU add: kind=00, aluop=00, rn=1, rm=2, rd=3, shift=00 → in order:
  - loada with readnum = 1;
  - loadb with readnum = 2;
  - loadc & loads;
  - write with writenum = 3, vsel = 0;
  - done on cycle 5 after accept; req_ready low for cycles 1–5.
- CMP: kind=01, aluop=01, rn=4, rm=4 → loads = 1, loadc = 0, write never asserted, done on cycle 4.
- MOV imm: kind=10, rd=7, imm=16'h00AB → write with writenum = 7, vsel = 1, imm_out = 16'h00AB in cycle 1; done in cycle 2.
- Back-to-back: req_valid held high with two requests → second accepted only on the edge after DONE; no strobe overlap between the two operations.
- Reset mid-op: assert rst_n low during LOAD_B of an ALU op → write never asserts, state returns to IDLE immediately; after release, a new MOV reg (rm=5, rd=0, shift=01) → asel = 1, aluop = 00 in EXEC, done on cycle 4.
